hovalaag_input_queue: RTL and testbench
=======================================

# hovalaag_input_queue

Dual-channel input buffer that sits directly upstream of the Hovalaag CPU and feeds its IN1/IN2 ports. A host or test harness pushes 12-bit words tagged for channel 1 or 2 through a valid/ready write port. Each channel has its own show-ahead FIFO whose head word is always presented to the CPU. The CPU's IN1_adv/IN2_adv strobes pop the heads. The block tracks occupancy and flags any read from an empty channel.

## Interface
- DEPTH, 16, entries per channel FIFO; power of two, ≥ 2
- AW, log2(DEPTH), pointer width; count ports are AW+1 bits
- clk  input  1  rising-edge clock, shared with the CPU
- rst  input  1  synchronous, active-high reset
- wr_data  input  12  word to enqueue
- wr_sel  input  1  target channel: 0 = IN1 FIFO, 1 = IN2 FIFO
- wr_valid  input  1  host offers wr_data this cycle
- wr_ready  output  1  selected FIFO can accept; transfer when wr_valid & wr_ready
- IN1  output  12  channel 1 head word; 12'h000 when empty
- IN1_adv  input  1  CPU consumed IN1 this cycle (pop)
- IN2  output  12  channel 2 head word; 12'h000 when empty
- IN2_adv  input  1  CPU consumed IN2 this cycle (pop)
- in1_count  output  AW+1  channel 1 occupancy, 0..DEPTH
- in2_count  output  AW+1  channel 2 occupancy, 0..DEPTH
- in1_empty, in2_empty  output  1 each  occupancy == 0
- underflow1, underflow2  output  1 each  sticky; set by a pop on an empty channel

## Operation
- Each channel has DEPTH×12 storage, a read pointer, a write pointer (each AW bits, wrap modulo DEPTH), and a count register (AW+1 bits).
- Write port:
  - wr_ready = !(count[wr_sel] == DEPTH), derived purely from the current count; it does not look ahead to a same-cycle pop.
  - On accept: storage[wr_ptr] <= wr_data; wr_ptr += 1; count += 1.
- Head output: IN = storage[rd_ptr] when count != 0, else 12'h000. The head is a combinational read of registered state, so the CPU samples the correct word in the cycle it asserts adv.
- Pop: on ch_adv with count != 0, rd_ptr += 1 and count -= 1.
- Pop on empty: pointers and count are unchanged and underflow is set. Underflow clears only on rst.
- Simultaneous write and pop on the same channel:
  - Count != 0: both take effect, count unchanged, pointers both advance.
  - Count == 0: the pop is an underflow and the written word becomes the head next cycle.
  - Count == DEPTH: the write is refused (wr_ready = 0) and the pop proceeds.
- The two channels are fully independent. Popping IN1 and IN2 in the same cycle is legal; the Hovalaag CPU never does so, but the block must handle it.
- Pointer wrap: wrapping from DEPTH-1 to 0 is seamless. FIFO order is preserved across any number of wraps.

## Timing
- rst has priority over all writes and pops in the same cycle.
- On the next edge after rst, all pointers and counts are 0 and underflow flags are 0.
- Outputs after reset: IN1 = IN2 = 0, inN_empty = 1, inN_count = 0, wr_ready = 1. Storage contents are not reset and are never visible while empty.
- A CPU in reset drives adv from its instruction bits. These strobes are ignored while rst = 1.
- rst asserted mid-stream discards all queued words in the same edge.
- Write-to-head latency: a word accepted at edge k appears on IN at edge k if the FIFO was empty, valid for sampling at edge k+1.
- Pop-to-next-head latency: after a pop at edge k, the next word is on IN immediately after edge k.
- Counts, empty, wr_ready and underflow are all registered-state derived and update one edge after the causing event. wr_ready additionally depends combinationally on wr_sel.
- Throughput: one write and one pop per channel per cycle, sustained.

## Test plan
- Reset: assert rst for 2 cycles while driving IN1_adv = 1 and wr_valid = 1 → IN1 = IN2 = 0, counts 0, underflow1 = 0, wr_ready = 1 after release.
- Ordering: write 12'h123, 12'h456 to ch1 and 12'hABC to ch2, then pulse IN1_adv twice and IN2_adv once → IN1 shows 123 then 456 then 000; IN2 shows ABC then 000; counts return to 0; no underflow.
- Full and wrap: write DEPTH words 0..15 to ch1 → count 16 and wr_ready = 0 for wr_sel = 0 but 1 for wr_sel = 1. Pop 4 and write 4 more (100..103), then drain → sequence 4..15, 100..103 exactly.
- Simultaneous push and pop: with count 3, write and pop ch2 every cycle for 20 cycles → count stays 3 and output order matches input order.
- Underflow: pop an empty ch1 → underflow1 = 1, count stays 0, IN1 = 0. Then write 12'h7FF → IN1 = 7FF; underflow1 stays 1 until rst.
- Full with concurrent pop: ch1 at count 16, wr_valid with wr_sel = 0 and IN1_adv in the same cycle → write refused, count 15, the refused word is absent from the drained sequence.

Source files
------------

// File: rtl/hovalaag_input_queue.sv
// Dual-channel show-ahead input queue feeding the Hovalaag CPU IN1/IN2 ports.
// A host pushes tagged 12-bit words through one valid/ready port. Each channel
// presents its head word combinationally and pops it on the CPU adv strobe.
module hovalaag_input_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   wr_data,
  input  logic          wr_sel,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [11:0]   IN1,
  input  logic          IN1_adv,
  output logic [11:0]   IN2,
  input  logic          IN2_adv,
  output logic [AW:0]   in1_count,
  output logic [AW:0]   in2_count,
  output logic          in1_empty,
  output logic          in2_empty,
  output logic          underflow1,
  output logic          underflow2
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [11:0]   mem [2][DEPTH];
  logic [AW-1:0] rd_ptr [2];
  logic [AW-1:0] wr_ptr [2];
  logic [AW:0]   cnt [2];
  logic [1:0]    uf;

  logic       accept;
  logic [1:0] adv;
  logic [1:0] nonempty;
  logic [1:0] push;
  logic [1:0] pop;

  // Handshake and per-channel push/pop qualification; ready ignores same-cycle pops.
  always_comb begin
    adv         = {IN2_adv, IN1_adv};
    nonempty[0] = (cnt[0] != '0);
    nonempty[1] = (cnt[1] != '0);
    wr_ready    = (cnt[wr_sel] != FULL_CNT);
    accept      = wr_valid && wr_ready;
    push[0]     = accept && !wr_sel;
    push[1]     = accept && wr_sel;
    pop         = adv & nonempty;
  end

  // Storage write; contents are deliberately not reset since an empty channel never shows them.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= wr_data;
    end
  end

  // Pointer, occupancy and sticky underflow update; reset overrides every push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      uf <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + 1'b1;
          2'b01:   cnt[c] <= cnt[c] - 1'b1;
          default: cnt[c] <= cnt[c];
        endcase
        if (adv[c] && !nonempty[c]) uf[c] <= 1'b1;
      end
    end
  end

  // Show-ahead head words, forced to zero while a channel is empty.
  always_comb begin
    IN1        = nonempty[0] ? mem[0][rd_ptr[0]] : 12'h000;
    IN2        = nonempty[1] ? mem[1][rd_ptr[1]] : 12'h000;
    in1_count  = cnt[0];
    in2_count  = cnt[1];
    in1_empty  = !nonempty[0];
    in2_empty  = !nonempty[1];
    underflow1 = uf[0];
    underflow2 = uf[1];
  end

endmodule

// File: tb/tb_hovalaag_input_queue.sv
// Directed self-checking bench for hovalaag_input_queue (DEPTH = 16).
module tb_hovalaag_input_queue;

  logic        clk;
  logic        rst;
  logic [11:0] wr_data;
  logic        wr_sel;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] IN1;
  logic        IN1_adv;
  logic [11:0] IN2;
  logic        IN2_adv;
  logic [4:0]  in1_count;
  logic [4:0]  in2_count;
  logic        in1_empty;
  logic        in2_empty;
  logic        underflow1;
  logic        underflow2;

  int vectors;
  int miscompares;

  hovalaag_input_queue #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_sel(wr_sel), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .IN1(IN1), .IN1_adv(IN1_adv), .IN2(IN2), .IN2_adv(IN2_adv),
    .in1_count(in1_count), .in2_count(in2_count),
    .in1_empty(in1_empty), .in2_empty(in2_empty),
    .underflow1(underflow1), .underflow2(underflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic sel, input logic [11:0] d);
    wr_sel   = sel;
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    IN1_adv  = 1'b1;
    wr_valid = 1'b1;
    wr_sel   = 1'b0;
    wr_data  = 12'h5A5;
    step();
    step();
    rst      = 1'b0;
    IN1_adv  = 1'b0;
    wr_valid = 1'b0;
    #1;
    vectors++; if (IN1 !== 12'h000) begin miscompares++; $display("FAIL reset_in1 got %h exp 000", IN1); end
    vectors++; if (IN2 !== 12'h000) begin miscompares++; $display("FAIL reset_in2 got %h exp 000", IN2); end
    vectors++; if (in1_count !== 5'd0) begin miscompares++; $display("FAIL reset_cnt1 got %0d exp 0", in1_count); end
    vectors++; if (in2_count !== 5'd0) begin miscompares++; $display("FAIL reset_cnt2 got %0d exp 0", in2_count); end
    vectors++; if (underflow1 !== 1'b0) begin miscompares++; $display("FAIL reset_uf1 got %b exp 0", underflow1); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
    vectors++; if (in1_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty1 got %b exp 1", in1_empty); end
  endtask

  task automatic test_ordering();
    push(1'b0, 12'h123);
    push(1'b0, 12'h456);
    push(1'b1, 12'hABC);
    vectors++; if (IN1 !== 12'h123) begin miscompares++; $display("FAIL order_head1 got %h exp 123", IN1); end
    vectors++; if (IN2 !== 12'hABC) begin miscompares++; $display("FAIL order_head2 got %h exp abc", IN2); end
    vectors++; if (in1_count !== 5'd2) begin miscompares++; $display("FAIL order_cnt1 got %0d exp 2", in1_count); end
    IN1_adv = 1'b1; step(); IN1_adv = 1'b0;
    vectors++; if (IN1 !== 12'h456) begin miscompares++; $display("FAIL order_second1 got %h exp 456", IN1); end
    IN1_adv = 1'b1; step(); IN1_adv = 1'b0;
    vectors++; if (IN1 !== 12'h000) begin miscompares++; $display("FAIL order_drained1 got %h exp 000", IN1); end
    IN2_adv = 1'b1; step(); IN2_adv = 1'b0;
    vectors++; if (IN2 !== 12'h000) begin miscompares++; $display("FAIL order_drained2 got %h exp 000", IN2); end
    vectors++; if (in1_count !== 5'd0 || in2_count !== 5'd0) begin miscompares++; $display("FAIL order_counts got %0d/%0d exp 0/0", in1_count, in2_count); end
    vectors++; if (underflow1 !== 1'b0 || underflow2 !== 1'b0) begin miscompares++; $display("FAIL order_uf got %b/%b exp 0/0", underflow1, underflow2); end
  endtask

  // Pointers start at 2 here, so filling and refilling crosses the wrap point.
  task automatic test_full_wrap();
    logic [11:0] exp_q [$];
    for (int i = 0; i < 16; i++) push(1'b0, 12'(i));
    vectors++; if (in1_count !== 5'd16) begin miscompares++; $display("FAIL full_cnt got %0d exp 16", in1_count); end
    wr_sel = 1'b0; #1;
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_sel0 got %b exp 0", wr_ready); end
    wr_sel = 1'b1; #1;
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_sel1 got %b exp 1", wr_ready); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (IN1 !== 12'(i)) begin miscompares++; $display("FAIL wrap_pop%0d got %h exp %h", i, IN1, 12'(i)); end
      IN1_adv = 1'b1; step(); IN1_adv = 1'b0;
    end
    for (int i = 0; i < 4; i++) push(1'b0, 12'h100 + 12'(i));
    for (int i = 4; i < 16; i++) exp_q.push_back(12'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(12'h100 + 12'(i));
    foreach (exp_q[i]) begin
      vectors++; if (IN1 !== exp_q[i]) begin miscompares++; $display("FAIL wrap_drain%0d got %h exp %h", i, IN1, exp_q[i]); end
      IN1_adv = 1'b1; step(); IN1_adv = 1'b0;
    end
    vectors++; if (in1_empty !== 1'b1 || IN1 !== 12'h000) begin miscompares++; $display("FAIL wrap_empty got %b/%h exp 1/000", in1_empty, IN1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) push(1'b1, 12'h200 + 12'(i));
    for (int i = 0; i < 20; i++) begin
      wr_sel   = 1'b1;
      wr_data  = 12'h203 + 12'(i);
      wr_valid = 1'b1;
      IN2_adv  = 1'b1;
      vectors++; if (IN2 !== 12'h200 + 12'(i)) begin miscompares++; $display("FAIL b2b_head%0d got %h exp %h", i, IN2, 12'h200 + 12'(i)); end
      step();
      vectors++; if (in2_count !== 5'd3) begin miscompares++; $display("FAIL b2b_cnt%0d got %0d exp 3", i, in2_count); end
    end
    wr_valid = 1'b0;
    IN2_adv  = 1'b0;
    for (int i = 20; i < 23; i++) begin
      vectors++; if (IN2 !== 12'h200 + 12'(i)) begin miscompares++; $display("FAIL b2b_tail%0d got %h exp %h", i, IN2, 12'h200 + 12'(i)); end
      IN2_adv = 1'b1; step(); IN2_adv = 1'b0;
    end
    vectors++; if (in2_empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty got %b exp 1", in2_empty); end
    vectors++; if (underflow2 !== 1'b0) begin miscompares++; $display("FAIL b2b_uf got %b exp 0", underflow2); end
  endtask

  task automatic test_underflow();
    do_reset();
    IN1_adv = 1'b1; step(); IN1_adv = 1'b0;
    vectors++; if (underflow1 !== 1'b1) begin miscompares++; $display("FAIL uf_set got %b exp 1", underflow1); end
    vectors++; if (in1_count !== 5'd0) begin miscompares++; $display("FAIL uf_cnt got %0d exp 0", in1_count); end
    vectors++; if (IN1 !== 12'h000) begin miscompares++; $display("FAIL uf_in1 got %h exp 000", IN1); end
    vectors++; if (underflow2 !== 1'b0) begin miscompares++; $display("FAIL uf_other got %b exp 0", underflow2); end
    push(1'b0, 12'h7FF);
    vectors++; if (IN1 !== 12'h7FF) begin miscompares++; $display("FAIL uf_head got %h exp 7ff", IN1); end
    vectors++; if (underflow1 !== 1'b1) begin miscompares++; $display("FAIL uf_sticky got %b exp 1", underflow1); end
    // Push and pop on an empty channel: underflow, and the word still lands.
    wr_sel = 1'b1; wr_data = 12'h5A5; wr_valid = 1'b1; IN2_adv = 1'b1;
    step();
    wr_valid = 1'b0; IN2_adv = 1'b0;
    vectors++; if (underflow2 !== 1'b1) begin miscompares++; $display("FAIL uf_pushpop_flag got %b exp 1", underflow2); end
    vectors++; if (IN2 !== 12'h5A5 || in2_count !== 5'd1) begin miscompares++; $display("FAIL uf_pushpop_head got %h/%0d exp 5a5/1", IN2, in2_count); end
    // Reset mid-stream with queued words and a concurrent pop.
    rst = 1'b1; IN1_adv = 1'b1; step(); rst = 1'b0; IN1_adv = 1'b0;
    vectors++; if (underflow1 !== 1'b0 || underflow2 !== 1'b0) begin miscompares++; $display("FAIL uf_clear got %b/%b exp 0/0", underflow1, underflow2); end
    vectors++; if (in1_count !== 5'd0 || in2_count !== 5'd0 || IN1 !== 12'h000 || IN2 !== 12'h000) begin
      miscompares++; $display("FAIL midreset got %0d/%0d %h/%h exp 0/0 000/000", in1_count, in2_count, IN1, IN2);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 16; i++) push(1'b0, 12'h300 + 12'(i));
    wr_sel = 1'b0; wr_data = 12'hEEE; wr_valid = 1'b1; IN1_adv = 1'b1;
    #1;
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL fullpop_ready got %b exp 0", wr_ready); end
    vectors++; if (IN1 !== 12'h300) begin miscompares++; $display("FAIL fullpop_head got %h exp 300", IN1); end
    step();
    wr_valid = 1'b0; IN1_adv = 1'b0;
    vectors++; if (in1_count !== 5'd15) begin miscompares++; $display("FAIL fullpop_cnt got %0d exp 15", in1_count); end
    for (int i = 1; i < 16; i++) begin
      vectors++; if (IN1 !== 12'h300 + 12'(i)) begin miscompares++; $display("FAIL fullpop_drain%0d got %h exp %h", i, IN1, 12'h300 + 12'(i)); end
      IN1_adv = 1'b1; step(); IN1_adv = 1'b0;
    end
    vectors++; if (in1_empty !== 1'b1 || IN1 !== 12'h000) begin miscompares++; $display("FAIL fullpop_empty got %b/%h exp 1/000", in1_empty, IN1); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; wr_data = '0; wr_sel = 1'b0; wr_valid = 1'b0; IN1_adv = 1'b0; IN2_adv = 1'b0;
    test_reset();
    test_ordering();
    test_full_wrap();
    test_back_to_back();
    test_underflow();
    test_full_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
